// File: rtl/l2cache_control.sv
// L2 cache controller: hit handling, dirty writeback and line allocation
// sequencing, plus saturating hit/miss/writeback performance counters.
module l2cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cache_read,
  input  logic                 cache_write,
  output logic                 cache_resp,
  input  logic                 way1_hit,
  input  logic                 way2_hit,
  input  logic                 dirty_out,
  input  logic                 LRU_out,
  output logic                 R_W,
  output logic                 load_data_1,
  output logic                 load_data_2,
  output logic                 dirty_bit,
  output logic                 load_dirty_1,
  output logic                 load_dirty_2,
  output logic                 load_LRU,
  output logic                 LRU_in,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 clr_counts,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic req;
  logic hit;
  logic miss_event;
  logic wb_event;

  assign req = cache_read | cache_write;
  assign hit = req & (way1_hit | way2_hit);

  // State register; reset abandons any in-flight memory transaction.
  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state and datapath/pmem control decode.
  always_comb begin
    state_next   = state_reg;
    cache_resp   = 1'b0;
    R_W          = 1'b0;
    load_data_1  = 1'b0;
    load_data_2  = 1'b0;
    dirty_bit    = 1'b0;
    load_dirty_1 = 1'b0;
    load_dirty_2 = 1'b0;
    load_LRU     = 1'b0;
    LRU_in       = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    miss_event   = 1'b0;
    wb_event     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          cache_resp = 1'b1;
          load_LRU   = 1'b1;
          // LRU points at the way that was not hit.
          LRU_in     = way1_hit;
          if (cache_write) begin
            R_W       = 1'b1;
            dirty_bit = 1'b1;
            if (way1_hit) begin
              load_data_1  = 1'b1;
              load_dirty_1 = 1'b1;
            end else begin
              load_data_2  = 1'b1;
              load_dirty_2 = 1'b1;
            end
          end
        end else if (req) begin
          miss_event = 1'b1;
          state_next = dirty_out ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        R_W        = 1'b1;
        pmem_write = 1'b1;
        if (pmem_resp) begin
          wb_event   = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          // Fill the victim way chosen by LRU; freshly loaded line is clean.
          if (LRU_out) begin
            load_data_2  = 1'b1;
            load_dirty_2 = 1'b1;
          end else begin
            load_data_1  = 1'b1;
            load_dirty_1 = 1'b1;
          end
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter bank: 0 = hits, 1 = misses, 2 = writebacks.
  logic [2:0]           cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_reg [3];

  assign cnt_inc = {wb_event, miss_event, cache_resp};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      // Saturating counter; clear wins over a same-cycle increment.
      always_ff @(posedge clk) begin
        if (!reset_n || clr_counts)
          cnt_reg[gi] <= '0;
        else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_WIDTH{1'b1}}))
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  endgenerate

  assign hit_count  = cnt_reg[0];
  assign miss_count = cnt_reg[1];
  assign wb_count   = cnt_reg[2];

endmodule

// File: tb/tb_l2cache_control.sv
// Scoreboard bench for l2cache_control: stimulus pushes the expected control
// vector of every active cycle; a monitor pops and compares on each cycle the
// DUT drives any control output.
module tb_l2cache_control;

  localparam int CW = 4;

  // Control vector bit positions.
  localparam logic [10:0] CR   = 11'b100_0000_0000;
  localparam logic [10:0] RW   = 11'b010_0000_0000;
  localparam logic [10:0] LD1  = 11'b001_0000_0000;
  localparam logic [10:0] LD2  = 11'b000_1000_0000;
  localparam logic [10:0] LDD1 = 11'b000_0100_0000;
  localparam logic [10:0] LDD2 = 11'b000_0010_0000;
  localparam logic [10:0] DB   = 11'b000_0001_0000;
  localparam logic [10:0] LLRU = 11'b000_0000_1000;
  localparam logic [10:0] LIN  = 11'b000_0000_0100;
  localparam logic [10:0] PR   = 11'b000_0000_0010;
  localparam logic [10:0] PW   = 11'b000_0000_0001;

  logic clk = 1'b0;
  logic reset_n, cache_read, cache_write, cache_resp;
  logic way1_hit, way2_hit, dirty_out, LRU_out;
  logic R_W, load_data_1, load_data_2, dirty_bit, load_dirty_1, load_dirty_2;
  logic load_LRU, LRU_in, pmem_read, pmem_write, pmem_resp, clr_counts;
  logic [CW-1:0] hit_count, miss_count, wb_count;

  typedef struct {
    logic [10:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  l2cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cache_read(cache_read), .cache_write(cache_write), .cache_resp(cache_resp),
    .way1_hit(way1_hit), .way2_hit(way2_hit), .dirty_out(dirty_out), .LRU_out(LRU_out),
    .R_W(R_W), .load_data_1(load_data_1), .load_data_2(load_data_2),
    .dirty_bit(dirty_bit), .load_dirty_1(load_dirty_1), .load_dirty_2(load_dirty_2),
    .load_LRU(load_LRU), .LRU_in(LRU_in), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .clr_counts(clr_counts),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  logic [10:0] act;
  assign act = {cache_resp, R_W, load_data_1, load_data_2, load_dirty_1, load_dirty_2,
                dirty_bit, load_LRU, LRU_in, pmem_read, pmem_write};

  // Monitor: compare each active cycle against the next scoreboard entry.
  always @(negedge clk) begin
    compared++;
    if (pmem_read && pmem_write) begin
      mismatched++;
      $display("FAIL pmem_excl: pmem_read=1 pmem_write=1 required not both");
    end
    if (load_data_1 && load_data_2) begin
      mismatched++;
      $display("FAIL load_excl: load_data_1=1 load_data_2=1 required not both");
    end
    if (|act) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected: act=%b required no activity", act);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (act !== e.v) begin
          mismatched++;
          $display("FAIL %s: act=%b required=%b", e.name, act, e.v);
        end else begin
          $display("txn %s: ctl=%b ok", e.name, act);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input logic [10:0] v, input string name);
    exp_t e;
    e.v = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int a, input int r);
    compared++;
    if (a != r) begin
      mismatched++;
      $display("FAIL %s: got=%0d required=%0d", name, a, r);
    end else begin
      $display("txn %s: %0d ok", name, a);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic h1, input logic h2,
                       input logic d, input logic l, input logic pr);
    cache_read = rd; cache_write = wr; way1_hit = h1; way2_hit = h2;
    dirty_out = d; LRU_out = l; pmem_resp = pr;
  endtask

  initial begin
    reset_n = 1'b0; clr_counts = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset_n = 1'b1;
    check("reset_hit", hit_count, 0);
    check("reset_miss", miss_count, 0);
    check("reset_wb", wb_count, 0);

    // Read hit in way 2.
    drive(1, 0, 0, 1, 0, 0, 0);
    expect_v(CR | LLRU, "read_hit_w2");
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("hit_after_read", hit_count, 1);

    // Write hit in way 1.
    drive(0, 1, 1, 0, 0, 0, 0);
    expect_v(CR | RW | LD1 | LDD1 | DB | LLRU | LIN, "write_hit_w1");
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("hit_after_write", hit_count, 2);

    // Clean read miss, LRU_out=1, memory answers in the third allocate cycle.
    drive(1, 0, 0, 0, 0, 1, 0);
    tick();
    check("miss_clean", miss_count, 1);
    expect_v(PR, "alloc_wait1");
    tick();
    expect_v(PR, "alloc_wait2");
    tick();
    pmem_resp = 1'b1;
    expect_v(PR | LD2 | LDD2, "alloc_fill_w2");
    tick();
    drive(1, 0, 0, 1, 0, 1, 0);
    expect_v(CR | LLRU, "retry_hit_w2");
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("hit_after_fill", hit_count, 3);
    check("wb_clean", wb_count, 0);

    // Clear, then dirty write miss with writeback.
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    check("clr_hit", hit_count, 0);
    drive(0, 1, 0, 0, 1, 0, 0);
    tick();
    dirty_out = 1'b0;
    expect_v(RW | PW, "wb_wait");
    tick();
    pmem_resp = 1'b1;
    expect_v(RW | PW, "wb_done");
    tick();
    check("wb_count", wb_count, 1);
    expect_v(PR | LD1 | LDD1, "alloc_fill_w1");
    tick();
    drive(0, 1, 1, 0, 0, 0, 0);
    expect_v(CR | RW | LD1 | LDD1 | DB | LLRU | LIN, "retry_write_hit");
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("miss_dirty", miss_count, 1);
    check("hit_dirty", hit_count, 1);

    // Saturation: 20 read hits in way 1 at CNT_WIDTH=4.
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0);
      expect_v(CR | LLRU | LIN, "sat_hit");
      tick();
    end
    check("hit_saturated", hit_count, 15);
    clr_counts = 1'b1;
    expect_v(CR | LLRU | LIN, "clr_with_hit");
    tick();
    clr_counts = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("clr_priority", hit_count, 0);

    // Reset in the middle of an allocate.
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    check("miss_before_rst", miss_count, 1);
    expect_v(PR, "alloc_pre_rst");
    tick();
    reset_n = 1'b0;
    cache_read = 1'b0;
    expect_v(PR, "alloc_in_rst");
    tick();
    reset_n = 1'b1;
    check("rst_miss", miss_count, 0);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    tick();
    tick();

    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
